// File: rtl/mdu_controller.sv
// mdu_controller: iterative radix-2 multiply/divide unit for the E stage.
// Owns the HI/LO pair, runs MULT/MULTU/DIV/DIVU in WIDTH steps plus one sign-fix
// cycle, services MTHI/MTLO and raises a stall while HI/LO results are pending.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   MDU_ValidE        E-stage instruction valid
//   MDU_OpE           3-bit op (none, MULT, MULTU, DIV, DIVU, MTHI, MTLO, reserved)
//   MDU_SrcAE/SrcBE   rs / rt operands
//   MDU_ReadHiLoD     MFHI/MFLO present in Decode
//   MDU_Stall         combinational stall request to the hazard unit
//   MDU_Busy          registered, high while in MUL/DIV/FIX
//   MDU_Hi/MDU_Lo     architectural HI/LO registers
module mdu_controller #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MDU_ValidE,
  input  logic [2:0]       MDU_OpE,
  input  logic [WIDTH-1:0] MDU_SrcAE,
  input  logic [WIDTH-1:0] MDU_SrcBE,
  input  logic             MDU_ReadHiLoD,
  output logic             MDU_Stall,
  output logic             MDU_Busy,
  output logic [WIDTH-1:0] MDU_Hi,
  output logic [WIDTH-1:0] MDU_Lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;       // {partial product | remainder, multiplier | quotient}
  logic                 r_is_div;
  logic                 r_neg_q;     // operand signs differ on a signed op
  logic                 r_neg_r;     // dividend negative on a signed divide
  logic                 r_busy;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  // ---------------- operation decode ----------------
  logic w_op_mul, w_op_div, w_op_md, w_op_any, w_op_signed;
  logic w_sign_a, w_sign_b, w_b_zero, w_start;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  assign w_op_mul    = (MDU_OpE == OP_MULT) || (MDU_OpE == OP_MULTU);
  assign w_op_div    = (MDU_OpE == OP_DIV)  || (MDU_OpE == OP_DIVU);
  assign w_op_md     = w_op_mul || w_op_div;
  assign w_op_any    = (MDU_OpE != 3'b000) && (MDU_OpE != 3'b111);
  assign w_op_signed = (MDU_OpE == OP_MULT) || (MDU_OpE == OP_DIV);

  assign w_sign_a = w_op_signed && MDU_SrcAE[WIDTH-1];
  assign w_sign_b = w_op_signed && MDU_SrcBE[WIDTH-1];
  // Negating the most-negative value yields itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  assign w_mag_a  = w_sign_a ? -MDU_SrcAE : MDU_SrcAE;
  assign w_mag_b  = w_sign_b ? -MDU_SrcBE : MDU_SrcBE;
  assign w_b_zero = (MDU_SrcBE == '0);

  // Divide-by-zero completes immediately, so it never starts the iterator.
  assign w_start = MDU_ValidE && w_op_md && !(w_op_div && w_b_zero);

  // ---------------- datapath step logic ----------------
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_top;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_acc_hi, w_acc_lo, w_quo, w_rem;

  assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo = r_acc[WIDTH-1:0];

  // Shift-add: conditionally add the multiplicand into the upper half, keeping
  // the carry so the following right shift does not lose it.
  assign w_mul_sum = {1'b0, w_acc_hi} +
                     (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Restoring divide: the shifted partial remainder needs WIDTH+1 bits since
  // the remainder can be as large as divisor-1 before the shift.
  assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = (w_div_top >= {1'b0, r_opnd});
  assign w_div_diff = w_div_top[WIDTH-1:0] - r_opnd;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -w_acc_lo : w_acc_lo;
  assign w_rem  = r_neg_r ? -w_acc_hi : w_acc_hi;

  // ---------------- next-state logic ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = w_op_div ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == CNT_ONE) begin
          w_next = S_FIX;
        end
      end
      S_DIV: begin
        if (r_cnt == CNT_ONE) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------- state and datapath registers ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (MDU_ValidE) begin
            if (w_op_mul) begin
              r_opnd   <= w_mag_a;
              r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
              r_cnt    <= CNT_INIT;
              r_is_div <= 1'b0;
              r_neg_q  <= w_sign_a ^ w_sign_b;
              r_neg_r  <= 1'b0;
            end else if (w_op_div) begin
              if (w_b_zero) begin
                r_hi <= MDU_SrcAE;
                r_lo <= '1;
              end else begin
                r_opnd   <= w_mag_b;
                r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                r_cnt    <= CNT_INIT;
                r_is_div <= 1'b1;
                r_neg_q  <= w_sign_a ^ w_sign_b;
                r_neg_r  <= w_sign_a;
              end
            end else if (MDU_OpE == OP_MTHI) begin
              r_hi <= MDU_SrcAE;
            end else if (MDU_OpE == OP_MTLO) begin
              r_lo <= MDU_SrcAE;
            end
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_DIV: begin
          r_acc <= w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                            : {r_acc[2*WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------- outputs ----------------
  // Second term: an MFHI/MFLO in D right behind a mult/div that is only now
  // being accepted must wait even though Busy is not yet set. MTHI/MTLO are
  // excluded there because their write lands before the reader reaches E.
  assign MDU_Stall = (r_busy && (MDU_ReadHiLoD || (MDU_ValidE && w_op_any))) ||
                     (MDU_ReadHiLoD && MDU_ValidE && w_op_md && (r_state == S_IDLE));
  assign MDU_Busy  = r_busy;
  assign MDU_Hi    = r_hi;
  assign MDU_Lo    = r_lo;

endmodule

// File: tb/tb_mdu_controller.sv
module tb_mdu_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MDU_ValidE = 1'b0;
  logic [2:0]  MDU_OpE = 3'b000;
  logic [31:0] MDU_SrcAE = 32'h0;
  logic [31:0] MDU_SrcBE = 32'h0;
  logic        MDU_ReadHiLoD = 1'b0;
  logic        MDU_Stall, MDU_Busy;
  logic [31:0] MDU_Hi, MDU_Lo;

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  mdu_controller #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .MDU_ValidE(MDU_ValidE), .MDU_OpE(MDU_OpE),
    .MDU_SrcAE(MDU_SrcAE), .MDU_SrcBE(MDU_SrcBE), .MDU_ReadHiLoD(MDU_ReadHiLoD),
    .MDU_Stall(MDU_Stall), .MDU_Busy(MDU_Busy), .MDU_Hi(MDU_Hi), .MDU_Lo(MDU_Lo)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Results are computed with plain wide arithmetic when an op is accepted and
  // revealed after WIDTH+1 edges; m_cnt is the number of edges still pending.
  int          m_cnt = 0;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0, p_hi = 32'h0, p_lo = 32'h0;
  logic signed [63:0] sa, sb;
  logic [63:0] ua, ub, pr, q, r;

  always @(posedge CLK) begin
    if (RST) begin
      m_cnt = 0; m_hi = 32'h0; m_lo = 32'h0;
    end else if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (MDU_ValidE) begin
      sa = {{32{MDU_SrcAE[31]}}, MDU_SrcAE};
      sb = {{32{MDU_SrcBE[31]}}, MDU_SrcBE};
      ua = {32'h0, MDU_SrcAE};
      ub = {32'h0, MDU_SrcBE};
      case (MDU_OpE)
        3'd1: begin pr = sa * sb; p_hi = pr[63:32]; p_lo = pr[31:0]; m_cnt = 33; end
        3'd2: begin pr = ua * ub; p_hi = pr[63:32]; p_lo = pr[31:0]; m_cnt = 33; end
        3'd3, 3'd4: begin
          if (MDU_SrcBE == 32'h0) begin
            m_hi = MDU_SrcAE; m_lo = 32'hFFFF_FFFF;
          end else begin
            if (MDU_OpE == 3'd3) begin q = sa / sb; r = sa % sb; end
            else begin q = ua / ub; r = ua % ub; end
            p_hi = r[31:0]; p_lo = q[31:0]; m_cnt = 33;
          end
        end
        3'd5: m_hi = MDU_SrcAE;
        3'd6: m_lo = MDU_SrcAE;
        default: ;
      endcase
    end
  end

  function automatic logic m_stall();
    logic busy, any_op, md_op;
    busy   = (m_cnt != 0);
    any_op = MDU_ValidE && (MDU_OpE >= 3'd1) && (MDU_OpE <= 3'd6);
    md_op  = MDU_ValidE && (MDU_OpE >= 3'd1) && (MDU_OpE <= 3'd4);
    return (busy && (MDU_ReadHiLoD || any_op)) || (MDU_ReadHiLoD && md_op && !busy);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // literal expectation applied to both the DUT and the model
  task automatic lit(input string nm, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    chk(nm, dut_v, exp);
    chk({nm, "_model"}, mdl_v, exp);
  endtask

  // cycle-by-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("stall", {31'h0, MDU_Stall}, {31'h0, m_stall()});
      chk("busy",  {31'h0, MDU_Busy},  {31'h0, m_cnt != 0});
      chk("hi",    MDU_Hi, m_hi);
      chk("lo",    MDU_Lo, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rd);
    MDU_ValidE = v; MDU_OpE = op; MDU_SrcAE = a; MDU_SrcBE = b; MDU_ReadHiLoD = rd;
  endtask

  // Issue one op for a single cycle, then count busy cycles over a fixed window.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    drive(1'b1, op, a, b, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (MDU_Busy) nbusy++;
      tick();
    end
  endtask

  int nb;

  initial begin
    tick();
    chk_on = 1'b1;
    lit("rst_hi", MDU_Hi, m_hi, 32'h0);
    lit("rst_lo", MDU_Lo, m_lo, 32'h0);
    chk("rst_busy", {31'h0, MDU_Busy}, 32'h0);
    tick();
    RST = 1'b0;

    // unsigned multiply, busy window length
    run_op(3'd2, 32'hFFFF_FFFF, 32'h2, nb);
    chk("multu_busy_cycles", nb, 33);
    lit("multu_hi", MDU_Hi, m_hi, 32'h0000_0001);
    lit("multu_lo", MDU_Lo, m_lo, 32'hFFFF_FFFE);

    run_op(3'd1, 32'hFFFF_FFFD, 32'h5, nb);
    lit("mult_hi", MDU_Hi, m_hi, 32'hFFFF_FFFF);
    lit("mult_lo", MDU_Lo, m_lo, 32'hFFFF_FFF1);

    run_op(3'd3, 32'hFFFF_FFF9, 32'h2, nb);
    chk("div_busy_cycles", nb, 33);
    lit("div_hi", MDU_Hi, m_hi, 32'hFFFF_FFFF);
    lit("div_lo", MDU_Lo, m_lo, 32'hFFFF_FFFD);

    run_op(3'd4, 32'h0000_1234, 32'h0, nb);
    chk("divz_busy_cycles", nb, 0);
    lit("divz_hi", MDU_Hi, m_hi, 32'h0000_1234);
    lit("divz_lo", MDU_Lo, m_lo, 32'hFFFF_FFFF);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    lit("divmin_hi", MDU_Hi, m_hi, 32'h0);
    lit("divmin_lo", MDU_Lo, m_lo, 32'h8000_0000);

    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, nb);
    lit("multmin_hi", MDU_Hi, m_hi, 32'h4000_0000);
    lit("multmin_lo", MDU_Lo, m_lo, 32'h0);

    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, nb);
    lit("div_negb_hi", MDU_Hi, m_hi, 32'h0000_0001);
    lit("div_negb_lo", MDU_Lo, m_lo, 32'hFFFF_FFFD);

    // stall with a reader in D; a second MULT held in E behind it
    drive(1'b1, 3'd2, 32'd3, 32'd4, 1'b1);
    #1;
    chk("stall_start", {31'h0, MDU_Stall}, 32'h1);
    tick();
    drive(1'b1, 3'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
    repeat (33) tick();
    lit("stall_mulu_hi", MDU_Hi, m_hi, 32'h0);
    lit("stall_mulu_lo", MDU_Lo, m_lo, 32'h0000_000C);
    chk("stall_idle_busy", {31'h0, MDU_Busy}, 32'h0);
    tick();
    chk("second_mult_accepted", {31'h0, MDU_Busy}, 32'h1);
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    repeat (34) tick();
    lit("second_mult_hi", MDU_Hi, m_hi, 32'h0);
    lit("second_mult_lo", MDU_Lo, m_lo, 32'h0000_0006);

    // MTLO with a reader in D: no stall, write at the edge
    drive(1'b1, 3'd6, 32'hCAFE_F00D, 32'h0, 1'b1);
    #1;
    chk("mtlo_no_stall", {31'h0, MDU_Stall}, 32'h0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    lit("mtlo_lo", MDU_Lo, m_lo, 32'hCAFE_F00D);

    // reserved and none ops leave HI/LO alone
    drive(1'b1, 3'd7, 32'h1111_1111, 32'h2222_2222, 1'b0);
    tick();
    drive(1'b1, 3'd0, 32'h3333_3333, 32'h4444_4444, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    lit("rsvd_lo", MDU_Lo, m_lo, 32'hCAFE_F00D);
    chk("rsvd_busy", {31'h0, MDU_Busy}, 32'h0);

    // MTHI held in E while a multiply is busy
    drive(1'b1, 3'd2, 32'd5, 32'd5, 1'b0);
    tick();
    drive(1'b1, 3'd5, 32'h0000_ABCD, 32'h0, 1'b0);
    #1;
    chk("mthi_busy_stall", {31'h0, MDU_Stall}, 32'h1);
    repeat (33) tick();
    lit("mthi_pre_hi", MDU_Hi, m_hi, 32'h0);
    lit("mthi_pre_lo", MDU_Lo, m_lo, 32'd25);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    lit("mthi_hi", MDU_Hi, m_hi, 32'h0000_ABCD);
    lit("mthi_lo", MDU_Lo, m_lo, 32'd25);

    // reset in the middle of a divide
    drive(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    repeat (10) tick();
    RST = 1'b1;
    tick();
    chk("rst_mid_busy", {31'h0, MDU_Busy}, 32'h0);
    chk("rst_mid_stall", {31'h0, MDU_Stall}, 32'h0);
    lit("rst_mid_hi", MDU_Hi, m_hi, 32'h0);
    lit("rst_mid_lo", MDU_Lo, m_lo, 32'h0);
    RST = 1'b0;

    run_op(3'd4, 32'd100, 32'd7, nb);
    lit("divu_hi", MDU_Hi, m_hi, 32'd2);
    lit("divu_lo", MDU_Lo, m_lo, 32'd14);

    run_op(3'd4, 32'hFFFF_FFFF, 32'h0001_0000, nb);
    lit("divu_big_hi", MDU_Hi, m_hi, 32'h0000_FFFF);
    lit("divu_big_lo", MDU_Lo, m_lo, 32'h0000_FFFF);

    repeat (3) tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Iterative multiply/divide controller that owns the HI/LO register pair and sequences radix-2 MULT/MULTU/DIV/DIVU operations issued from the Execute stage.
- Sits beside the ALU in the E stage.
- Its stall request is ORed by the hazard logic into StallF/StallD/FlushE, so dependent instructions wait while a multi-cycle operation is in flight.
- Also services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count per mult/div equals WIDTH

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
MDU_ValidE  input  1  E-stage instruction valid (already 0 when E is flushed)
MDU_OpE  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
MDU_SrcAE  input  WIDTH  rs operand (multiplicand / dividend / MT data)
MDU_SrcBE  input  WIDTH  rt operand (multiplier / divisor)
MDU_ReadHiLoD  input  1  MFHI or MFLO present in Decode
MDU_Stall  output  1  stall request to the hazard logic (combinational)
MDU_Busy  output  1  mult/div in progress (registered)
MDU_Hi  output  WIDTH  HI register
MDU_Lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE, MDU_Hi=0, MDU_Lo=0, MDU_Busy=0, iteration counter=0, MDU_Stall=0. Reset during any state aborts the operation and leaves HI/LO=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, MDU_ValidE=1:
  - MULT/MULTU with divisor-independent start: latch |A|, |B| (signed ops) or raw (unsigned), record sign flags, clear the 2W accumulator, counter=WIDTH, go to MUL.
  - DIV/DIVU, SrcB≠0: latch magnitudes and signs, counter=WIDTH, go to DIV.
  - DIV/DIVU, SrcB=0: no iteration; at that edge HI=SrcA, LO=all ones; stay IDLE.
  - MTHI: HI=SrcA at that edge, single cycle. MTLO: LO=SrcA at that edge, single cycle. No busy in either case.
- MUL: one shift-add step per cycle, decrement counter; leaving when counter reaches 1 after the step goes to FIX.
- DIV: one restoring shift-subtract step per cycle (quotient bit 1 when partial remainder ≥ divisor); go to FIX after WIDTH steps.
- FIX (1 cycle):
  - MULT: negate the 2W product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - Unsigned ops pass through unchanged.
  - Write HI=upper/remainder and LO=lower/quotient; go to IDLE.
- Latency: op accepted at edge N, HI/LO updated at edge N+WIDTH+1 (33 for WIDTH=32). MDU_Busy is high from edge N through edge N+WIDTH+1, i.e. in states MUL/DIV/FIX.
- HI/LO change only at reset, FIX, MT writes, or divide-by-zero. Intermediate accumulation uses separate registers, so HI/LO keep their old values while busy.
- MDU_Stall = (MDU_Busy AND (MDU_ReadHiLoD OR (MDU_ValidE AND MDU_OpE in 001..110))) OR (MDU_ReadHiLoD AND MDU_ValidE AND MDU_OpE in 001..100 AND state=IDLE).
  - The second term covers an MFHI/MFLO in D immediately behind a just-starting mult/div.
  - A new MDU op held in E by the stall is accepted in the first IDLE cycle, i.e. the cycle the stall drops.
- An MTHI/MTLO in E with an MFHI/MFLO in D causes no stall: the write lands at the edge and the reader sees the new value in E.
- A 111 op or a 000 op while IDLE has no effect.
- All arithmetic is modulo 2^WIDTH per half. Signed magnitude of the most-negative value is 2^(WIDTH-1) as unsigned, with correct results (e.g. DIV 0x80000000/−1 gives LO=0x80000000, HI=0).

Test Plan:
- After reset, MULTU A=0xFFFFFFFF B=2, ValidE for 1 cycle -> MDU_Busy high 33 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
- MULT A=0xFFFFFFFD(−3) B=5 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV A=0xFFFFFFF9(−7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=0x1234 B=0 -> next edge HI=0x00001234, LO=0xFFFFFFFF, MDU_Busy never asserts.
- Start MULTU 3×4, then hold MDU_ReadHiLoD=1 -> MDU_Stall=1 in the start cycle and every busy cycle, dropping the cycle after HI=0, LO=0x0000000C are written. A second MULT held in E is accepted in that same cycle.
- MTLO 0xCAFEF00D with MDU_ReadHiLoD=1 in the same cycle -> MDU_Stall=0, LO=0xCAFEF00D next edge. MTHI issued while busy -> stalled, applied after FIX.
- Assert RST at iteration 10 of a DIV -> next edge state IDLE, MDU_Busy=0, HI=LO=0, MDU_Stall=0. A subsequent DIVU 100/7 gives LO=14, HI=2.
